multicycle_control_unit: RTL and testbench

Sequenced successor to the single-cycle instruction decoder. It drives the datapath through fetch, decode, execute, memory and writeback states over multiple clock cycles, using ready/ack handshakes on instruction and data memory. When `MISALIGNED_SPLIT` is 1, a load or store that crosses a word boundary is split into two memory beats; when it is 0, such an access raises a trap. Illegal opcodes also raise a trap. It sits between the instruction register / fetch interface and the register file, ALU and data memory controller.

---
 rtl/multicycle_control_unit_if.sv | 33 +++
 rtl/multicycle_control_unit.sv | 85 ++++++++
 tb/tb_multicycle_control_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: memory handshakes and datapath control bundle for the multicycle control unit
interface multicycle_control_unit_if;
  logic [31:0] instr;
  logic imem_valid;
  logic [1:0] alu_addr;
  logic dmem_ack;
  logic imem_req;
  logic ir_write_en;
  logic [3:0] alu_op;
  logic alu_a_src;
  logic alu_b_src;
  logic [2:0] branch_cond;
  logic [1:0] rd_src;
  logic [2:0] data_size;
  logic reg_write_en;
  logic pc_write_en;
  logic data_read_en;
  logic data_write_en;
  logic mem_beat;
  logic trap;
  logic [1:0] trap_cause;
  logic [2:0] state;
  modport master(
    input instr, imem_valid, alu_addr, dmem_ack,
    output imem_req, ir_write_en, alu_op, alu_a_src, alu_b_src, branch_cond, rd_src, data_size,
    output reg_write_en, pc_write_en, data_read_en, data_write_en, mem_beat, trap, trap_cause, state
  );
  modport slave(
    output instr, imem_valid, alu_addr, dmem_ack,
    input imem_req, ir_write_en, alu_op, alu_a_src, alu_b_src, branch_cond, rd_src, data_size,
    input reg_write_en, pc_write_en, data_read_en, data_write_en, mem_beat, trap, trap_cause, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: sequences fetch/decode/exec/mem/wb with memory handshakes, split accesses and traps
module multicycle_control_unit #(
  parameter bit MISALIGNED_SPLIT = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input logic clk,
  input logic rst,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM1, MEM2, WB, TRAP} state_t;
  state_t state, state_n;
  logic is_load, is_store, wr_rd, split, mem, split_n;
  logic [3:0] d_op;
  logic d_a, d_b, d_load, d_store, d_wr, d_ill, f7;
  logic [2:0] d_cond, d_size, f3;
  logic [1:0] d_rd;
  logic unused;
  assign f3 = bus.instr[14:12];
  assign f7 = bus.instr[30];
  assign unused = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
  assign mem = is_load | is_store;
  assign split_n = mem && (bus.data_size[1:0] == 2'b10 ? bus.alu_addr != 2'b00 :
                           bus.data_size[1:0] == 2'b01 && bus.alu_addr == 2'b11);
  always_comb begin
    d_op = 4'b0000;
    d_a = 1'b1;
    d_b = 1'b1;
    d_cond = 3'b010;
    d_rd = 2'b00;
    d_size = 3'b000;
    d_load = 1'b0;
    d_store = 1'b0;
    d_wr = 1'b0;
    d_ill = 1'b0;
    case (bus.instr[6:0])
      7'b0110011: begin d_op = {f7, f3}; d_wr = 1'b1; end
      7'b0010011: begin d_op = {f3 == 3'b101 && f7, f3}; d_b = 1'b0; d_wr = 1'b1; end
      7'b1100011: begin d_a = 1'b0; d_b = 1'b0; d_cond = f3; end
      7'b1101111: begin d_a = 1'b0; d_b = 1'b0; d_cond = 3'b011; d_rd = 2'b10; d_wr = 1'b1; end
      7'b1100111: begin d_b = 1'b0; d_cond = 3'b011; d_rd = 2'b10; d_wr = 1'b1; end
      7'b0110111: begin d_op = 4'b1001; d_b = 1'b0; d_wr = 1'b1; end
      7'b0010111: begin d_a = 1'b0; d_b = 1'b0; d_wr = 1'b1; end
      7'b0000011: begin d_b = 1'b0; d_rd = 2'b01; d_size = f3; d_load = 1'b1; d_wr = 1'b1; end
      7'b0100011: begin d_b = 1'b0; d_size = f3; d_store = 1'b1; end
      default: d_ill = 1'b1;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      FETCH: state_n = bus.imem_valid ? DECODE : FETCH;
      DECODE: state_n = d_ill && ILLEGAL_TRAP ? TRAP : EXEC;
      EXEC: state_n = !mem ? WB : split_n && !MISALIGNED_SPLIT ? TRAP : MEM1;
      MEM1: state_n = !bus.dmem_ack ? MEM1 : split ? MEM2 : WB;
      MEM2: state_n = bus.dmem_ack ? WB : MEM2;
      WB: state_n = FETCH;
      default: state_n = TRAP;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      {bus.alu_op, bus.alu_a_src, bus.alu_b_src, bus.branch_cond, bus.rd_src, bus.data_size} <= 14'b0000_1_1_010_00_000;
      {is_load, is_store, wr_rd, split} <= 4'b0000;
      bus.trap_cause <= 2'd0;
    end else begin
      state <= state_n;
      if (state == DECODE) begin
        {bus.alu_op, bus.alu_a_src, bus.alu_b_src, bus.branch_cond, bus.rd_src, bus.data_size} <= {d_op, d_a, d_b, d_cond, d_rd, d_size};
        {is_load, is_store, wr_rd} <= {d_load, d_store, d_wr};
      end
      if (state == EXEC) split <= split_n;
      if (state != TRAP && state_n == TRAP) bus.trap_cause <= state == DECODE ? 2'd1 : 2'd2;
    end
  end
  assign bus.state = state;
  assign bus.imem_req = !rst && state == FETCH;
  assign bus.ir_write_en = bus.imem_req && bus.imem_valid;
  assign bus.data_read_en = !rst && (state == MEM1 || state == MEM2) && is_load;
  assign bus.data_write_en = !rst && (state == MEM1 || state == MEM2) && is_store;
  assign bus.mem_beat = !rst && state == MEM2;
  assign bus.reg_write_en = !rst && state == WB && wr_rd;
  assign bus.pc_write_en = !rst && state == WB;
  assign bus.trap = !rst && state == TRAP;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized trace-model bench for both split/trap configurations
module tb_multicycle_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic imem_valid = 1'b0;
  logic dmem_ack = 1'b0;
  logic [1:0] alu_addr = 2'd0;
  bit use0 = 1'b0;
  bit trapped = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [12:0] o_vec;
  logic [13:0] o_fld;
  localparam logic [13:0] RST_FLD = 14'b0000_1_1_010_00_000;
  multicycle_control_unit_if b1();
  multicycle_control_unit_if b0();
  assign b1.instr = instr;
  assign b1.imem_valid = imem_valid;
  assign b1.alu_addr = alu_addr;
  assign b1.dmem_ack = dmem_ack;
  assign b0.instr = instr;
  assign b0.imem_valid = imem_valid;
  assign b0.alu_addr = alu_addr;
  assign b0.dmem_ack = dmem_ack;
  multicycle_control_unit #(.MISALIGNED_SPLIT(1'b1), .ILLEGAL_TRAP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  multicycle_control_unit #(.MISALIGNED_SPLIT(1'b0), .ILLEGAL_TRAP(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  always #5 clk = ~clk;
  assign o_vec = use0 ?
    {b0.state, b0.imem_req, b0.ir_write_en, b0.data_read_en, b0.data_write_en, b0.mem_beat, b0.reg_write_en, b0.pc_write_en, b0.trap, b0.trap_cause} :
    {b1.state, b1.imem_req, b1.ir_write_en, b1.data_read_en, b1.data_write_en, b1.mem_beat, b1.reg_write_en, b1.pc_write_en, b1.trap, b1.trap_cause};
  assign o_fld = use0 ?
    {b0.alu_op, b0.alu_a_src, b0.alu_b_src, b0.branch_cond, b0.rd_src, b0.data_size} :
    {b1.alu_op, b1.alu_a_src, b1.alu_b_src, b1.branch_cond, b1.rd_src, b1.data_size};

  function automatic logic [3:0] ref_kind(input logic [31:0] i);
    case (i[6:0])
      7'h33, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17: return 4'b1100;
      7'h63: return 4'b1000;
      7'h03: return 4'b1110;
      7'h23: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [13:0] ref_fields(input logic [31:0] i);
    logic [3:0] op = 4'd0;
    logic a = 1'b1;
    logic b = 1'b1;
    logic [2:0] c = 3'b010;
    logic [2:0] sz = 3'd0;
    logic [1:0] rs = 2'd0;
    logic [2:0] f3 = i[14:12];
    case (i[6:0])
      7'h33: op = {i[30], f3};
      7'h13: begin op = {f3 == 3'd5 ? i[30] : 1'b0, f3}; b = 1'b0; end
      7'h63: begin a = 1'b0; b = 1'b0; c = f3; end
      7'h6F: begin a = 1'b0; b = 1'b0; c = 3'b011; rs = 2'b10; end
      7'h67: begin b = 1'b0; c = 3'b011; rs = 2'b10; end
      7'h37: begin op = 4'b1001; b = 1'b0; end
      7'h17: begin a = 1'b0; b = 1'b0; end
      7'h03: begin b = 1'b0; rs = 2'b01; sz = f3; end
      7'h23: begin b = 1'b0; sz = f3; end
      default: ;
    endcase
    return {op, a, b, c, rs, sz};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h03, 7'h23, 7'h7F, 7'h0F, 7'h73};
    logic [2:0] lds [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [31:0] i = $urandom;
    i[6:0] = ops[$urandom_range(11, 0)];
    if (i[6:0] == 7'h03) i[14:12] = lds[$urandom_range(4, 0)];
    if (i[6:0] == 7'h23) i[14:12] = 3'($urandom_range(2, 0));
    return i;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_valid = 1'b0;
    dmem_ack = 1'b0;
    step();
    rst = 1'b0;
    trapped = 1'b0;
  endtask

  task automatic run(input logic [31:0] ins, input logic [1:0] addr, input int iw, input int w1, input int w2, input string name);
    int st[$];
    logic [3:0] k4 = ref_kind(ins);
    bit ms = !use0;
    bit it = !use0;
    int bytes = 1 << ins[13:12];
    bit split = (k4[1] | k4[0]) && (int'(addr) + bytes > 4);
    logic [1:0] cause = 2'd0;
    logic [12:0] ev;
    if (trapped) do_reset();
    instr = ins;
    repeat (iw + 1) st.push_back(0);
    st.push_back(1);
    if (!k4[3] && it) begin
      repeat (3) st.push_back(6);
      cause = 2'd1;
    end else begin
      st.push_back(2);
      if ((k4[1] | k4[0]) && split && !ms) begin
        repeat (3) st.push_back(6);
        cause = 2'd2;
      end else begin
        if (k4[1] | k4[0]) begin
          repeat (w1 + 1) st.push_back(3);
          if (split) repeat (w2 + 1) st.push_back(4);
        end
        st.push_back(5);
        st.push_back(0);
      end
    end
    trapped = cause != 2'd0;
    for (int k = 0; k < st.size(); k++) begin
      int s = st[k];
      int nx = k + 1 < st.size() ? st[k + 1] : s;
      imem_valid = s == 0 ? nx == 1 : 1'($urandom);
      dmem_ack = (s == 3 || s == 4) ? nx != s : 1'($urandom);
      alu_addr = s == 2 ? addr : 2'($urandom);
      ev = {3'(s), s == 0, s == 0 && imem_valid, (s == 3 || s == 4) && k4[1], (s == 3 || s == 4) && k4[0],
            s == 4, s == 5 && k4[2], s == 5, s == 6, s == 6 ? cause : 2'd0};
      @(negedge clk);
      checks++;
      if (o_vec !== ev) begin
        errors++;
        $display("FAIL %s instr=%h cycle %0d: outputs %b, required %b", name, ins, k, o_vec, ev);
      end
      if (s == 2) begin
        checks++;
        if (o_fld !== ref_fields(ins)) begin
          errors++;
          $display("FAIL %s_fields instr=%h: fields %b, required %b", name, ins, o_fld, ref_fields(ins));
        end
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_valid = 1'b1;
    dmem_ack = 1'b1;
    step();
    for (int u = 0; u < 2; u++) begin
      use0 = u[0];
      #1;
      checks++;
      if (o_vec !== 13'd0) begin errors++; $display("FAIL reset_outputs dut%0d: %b, required %b", u, o_vec, 13'd0); end
      checks++;
      if (o_fld !== RST_FLD) begin errors++; $display("FAIL reset_fields dut%0d: %b, required %b", u, o_fld, RST_FLD); end
    end
    use0 = 1'b0;
    imem_valid = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_vec !== {3'd0, 1'b1, 9'd0}) begin errors++; $display("FAIL reset_release: %b, required %b", o_vec, {3'd0, 1'b1, 9'd0}); end
    step();
  endtask

  task automatic test_addi();
    run(32'h00500093, 2'd0, 0, 0, 0, "addi");
  endtask

  task automatic test_lw_wait();
    run(32'h00012083, 2'd0, 0, 2, 0, "lw_wait");
  endtask

  task automatic test_sw_split();
    run(32'h00112023, 2'd2, 0, 0, 0, "sw_split");
  endtask

  task automatic test_sh();
    run(32'h00111023, 2'd1, 1, 0, 0, "sh_nosplit");
    run(32'h00111023, 2'd3, 0, 1, 2, "sh_split");
  endtask

  task automatic test_illegal();
    run(32'h0000007F, 2'd0, 0, 0, 0, "illegal");
    for (int k = 0; k < 10; k++) begin
      imem_valid = 1'($urandom);
      dmem_ack = 1'($urandom);
      @(negedge clk);
      checks++;
      if (o_vec !== {3'd6, 7'd0, 1'b1, 2'd1}) begin errors++; $display("FAIL trap_hold cycle %0d: %b, required %b", k, o_vec, {3'd6, 7'd0, 1'b1, 2'd1}); end
      step();
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (o_vec !== {3'd0, 1'b1, 9'd0}) begin errors++; $display("FAIL trap_exit: %b, required %b", o_vec, {3'd0, 1'b1, 9'd0}); end
    step();
  endtask

  task automatic test_rst_mem2();
    do_reset();
    instr = 32'h00012083;
    imem_valid = 1'b1;
    step();
    imem_valid = 1'b0;
    step();
    alu_addr = 2'd1;
    step();
    dmem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (o_vec !== {3'd3, 2'b00, 1'b1, 7'd0}) begin errors++; $display("FAIL rst_mem2_mem1: %b, required %b", o_vec, {3'd3, 2'b00, 1'b1, 7'd0}); end
    step();
    dmem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (o_vec !== {3'd4, 10'd0}) begin errors++; $display("FAIL rst_mem2_during: %b, required %b", o_vec, {3'd4, 10'd0}); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (o_vec !== {3'd0, 1'b1, 9'd0}) begin errors++; $display("FAIL rst_mem2_after: %b, required %b", o_vec, {3'd0, 1'b1, 9'd0}); end
    checks++;
    if (o_fld !== RST_FLD) begin errors++; $display("FAIL rst_mem2_fields: %b, required %b", o_fld, RST_FLD); end
    step();
  endtask

  task automatic test_lh_trap();
    run(32'h00011083, 2'd3, 0, 0, 0, "lh_trap");
  endtask

  task automatic test_nop_illegal();
    run(32'h0000007F, 2'd0, 0, 0, 0, "nop_illegal");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      bit u = 1'($urandom);
      if (u != use0) begin
        use0 = u;
        do_reset();
      end
      run(rand_instr(), 2'($urandom), $urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(2, 0), "random");
    end
  endtask

  initial begin
    test_reset();
    use0 = 1'b0;
    test_addi();
    test_lw_wait();
    test_sw_split();
    test_sh();
    test_illegal();
    test_rst_mem2();
    use0 = 1'b1;
    do_reset();
    test_lh_trap();
    test_nop_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
